// File: rtl/quad_paddle_decoder.sv
// quad_paddle_decoder: quadrature encoder front end for the pong paddle.
// Two-flop synchronizers feed a transition decoder that steps a saturating
// position accumulator; the accumulator is published to the game logic once
// per frame. Define QUAD_GLITCH_FILTER_EN to insert a per-phase stability
// filter (FILTER_CYCLES samples) between the synchronizers and the decoder.
//
// Output strobe: pos_valid is a one-cycle, ready-less strobe. It is high for
// exactly the cycle in which paddle_pos carries a newly latched value; the
// consumer has no back-pressure and must take the value in that cycle.
`timescale 1ns/1ps
module quad_paddle_decoder #(
  parameter int PADDLE_MAX    = 400,
  parameter int PADDLE_INIT   = 200,
  parameter int STEP          = 2,
  parameter int FILTER_CYCLES = 8
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       QUAD_A,
  input  logic       QUAD_B,
  input  logic       frame_tick,
  output logic [9:0] paddle_pos,
  output logic       pos_valid,
  output logic       dir,
  output logic       err,
  output logic [7:0] LED
);

  localparam logic [10:0] MAX_W  = 11'(PADDLE_MAX);
  localparam logic [10:0] STEP_W = 11'(STEP);

  // Cycles after reset during which the pipeline still carries reset values;
  // the decoder only tracks (never acts) until the first real sample arrives.
`ifdef QUAD_GLITCH_FILTER_EN
  localparam logic [2:0] PRIME_LEN = 3'd4;
`else
  localparam logic [2:0] PRIME_LEN = 3'd3;
`endif

  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic       cur_a;
  logic       cur_b;
  logic [1:0] prev_ab;
  logic [1:0] cur_ab;
  logic [2:0] prime_cnt;
  logic       priming;
  logic       step_inc;
  logic       step_dec;
  logic       step_bad;
  logic       mv_inc;
  logic       mv_dec;
  logic [9:0] acc;
  logic [10:0] acc_wide;
  logic [10:0] acc_up;
  logic [10:0] acc_down;
  logic [9:0] acc_next;

  assign priming = (prime_cnt != PRIME_LEN);

  // Two-flop synchronizers for the asynchronous encoder phases.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
    end else begin
      sync_a <= {sync_a[0], QUAD_A};
      sync_b <= {sync_b[0], QUAD_B};
    end
  end

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          filt_a;
  logic          filt_b;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  // Per-phase filter: adopt a new level only after it has been seen for
  // FILTER_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      filt_a <= 1'b0;
      filt_b <= 1'b0;
      cnt_a  <= '0;
      cnt_b  <= '0;
    end else if (priming) begin
      filt_a <= sync_a[1];
      filt_b <= sync_b[1];
      cnt_a  <= '0;
      cnt_b  <= '0;
    end else begin
      if (sync_a[1] == filt_a) begin
        cnt_a <= '0;
      end else if (cnt_a == CNT_LAST) begin
        filt_a <= sync_a[1];
        cnt_a  <= '0;
      end else begin
        cnt_a <= cnt_a + CW'(1);
      end
      if (sync_b[1] == filt_b) begin
        cnt_b <= '0;
      end else if (cnt_b == CNT_LAST) begin
        filt_b <= sync_b[1];
        cnt_b  <= '0;
      end else begin
        cnt_b <= cnt_b + CW'(1);
      end
    end
  end

  assign cur_a = filt_a;
  assign cur_b = filt_b;
`else
  assign cur_a = sync_a[1];
  assign cur_b = sync_b[1];
`endif

  assign cur_ab = {cur_a, cur_b};

  // Classify the previous->current AB pair as increment, decrement or illegal.
  always_comb begin
    step_inc = 1'b0;
    step_dec = 1'b0;
    step_bad = 1'b0;
    if (!priming && (cur_ab != prev_ab)) begin
      case ({prev_ab, cur_ab})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: step_inc = 1'b1;
        4'b0100, 4'b1101, 4'b1011, 4'b0010: step_dec = 1'b1;
        default:                            step_bad = 1'b1;
      endcase
    end
  end

  // Track the previous pair, register the detected move, update dir/err.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      prev_ab   <= 2'b00;
      prime_cnt <= 3'd0;
      mv_inc    <= 1'b0;
      mv_dec    <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      mv_inc  <= step_inc;
      mv_dec  <= step_dec;
      if (priming) prime_cnt <= prime_cnt + 3'd1;
      if (step_inc) dir <= 1'b1;
      if (step_dec) dir <= 1'b0;
      if (step_bad) err <= 1'b1;
    end
  end

  // Saturating next accumulator value, computed in 11 bits so it cannot wrap.
  always_comb begin
    acc_wide = {1'b0, acc};
    acc_up   = acc_wide + STEP_W;
    acc_down = acc_wide - STEP_W;
    acc_next = acc;
    if (mv_inc) begin
      acc_next = (acc_up > MAX_W) ? MAX_W[9:0] : acc_up[9:0];
    end else if (mv_dec) begin
      acc_next = (acc_wide < STEP_W) ? 10'd0 : acc_down[9:0];
    end
  end

  // Internal position accumulator.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      acc <= 10'(PADDLE_INIT);
    end else begin
      acc <= acc_next;
    end
  end

  // Publish the pre-update accumulator once per frame with a one-cycle strobe.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      paddle_pos <= 10'(PADDLE_INIT);
      pos_valid  <= 1'b0;
    end else begin
      pos_valid <= frame_tick;
      if (frame_tick) paddle_pos <= acc;
    end
  end

  assign LED = paddle_pos[9:2];

endmodule

// File: tb/tb_quad_paddle_decoder.sv
// Directed bench for quad_paddle_decoder (default parameters). Inputs are
// driven on the falling edge; outputs are sampled on the falling edge.
// Filter-specific steps are included when QUAD_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module tb_quad_paddle_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       qa = 1'b0;
  logic       qb = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] paddle_pos;
  logic       pos_valid;
  logic       dir;
  logic       err;
  logic [7:0] led;

  int n_cmp = 0;
  int n_fail = 0;
  int pv_count = 0;
  logic [1:0] ab_now = 2'b00;

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int HOLD_FAST = 14;
  localparam int LAT = 10;
`else
  localparam int HOLD_FAST = 3;
  localparam int LAT = 2;
`endif

  quad_paddle_decoder dut (
    .CLOCK_50   (clk),
    .RESET      (rst_n),
    .QUAD_A     (qa),
    .QUAD_B     (qb),
    .frame_tick (frame_tick),
    .paddle_pos (paddle_pos),
    .pos_valid  (pos_valid),
    .dir        (dir),
    .err        (err),
    .LED        (led)
  );

  // Clock: 50 MHz.
  always #10 clk = ~clk;

  // Running count of strobes, used to prove no publish happens without a tick.
  always @(negedge clk) if (pos_valid === 1'b1) pv_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ab(input logic [1:0] ab, input int n);
    qa = ab[1];
    qb = ab[0];
    ab_now = ab;
    cycles(n);
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic do_reset(input logic [1:0] ab);
    rst_n = 1'b0;
    drive_ab(ab, 2);
    rst_n = 1'b1;
    cycles(8);
  endtask

  // One-cycle frame_tick, then check the strobe, value, LED and no extra strobes.
  task automatic do_frame(input string tag, input int exp_pos);
    int extra;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check({tag, "_valid"}, 32'(pos_valid), 1);
    check({tag, "_pos"}, 32'(paddle_pos), exp_pos);
    check({tag, "_led"}, 32'(led), exp_pos / 4);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (pos_valid !== 1'b0) extra++;
    end
    check({tag, "_extra_strobes"}, extra, 0);
  endtask

  initial begin
    int pv_snap;
    @(negedge clk);

    // Reset state.
    do_reset(2'b00);
    check("rst_pos", 32'(paddle_pos), 200);
    check("rst_valid", 32'(pos_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_led", 32'(led), 50);

    // One full forward cycle: four increments of 2.
    for (int i = 0; i < 4; i++) drive_ab(fwd(ab_now), 20);
    check("fwd_dir", 32'(dir), 1);
    check("fwd_err", 32'(err), 0);
    do_frame("fwd", 208);

    // Upper saturation, then one decrement off the rail.
    for (int i = 0; i < 300; i++) drive_ab(fwd(ab_now), HOLD_FAST);
    cycles(LAT + 4);
    check("sat_hold_pos", 32'(paddle_pos), 208);
    do_frame("sat", 400);
    drive_ab(rev(ab_now), 20);
    check("sat_dec_dir", 32'(dir), 0);
    do_frame("sat_dec", 398);

    // Illegal transitions: both bits change; no movement, err sticks.
    do_reset(2'b00);
    check("ill_rst_pos", 32'(paddle_pos), 200);
    drive_ab(2'b11, 20);
    check("ill_err", 32'(err), 1);
    check("ill_dir", 32'(dir), 0);
    drive_ab(2'b00, 20);
    check("ill_err_sticky", 32'(err), 1);
    do_frame("ill", 200);

    // Frame stability: ten decrements with no tick leave paddle_pos alone.
    pv_snap = pv_count;
    for (int i = 0; i < 10; i++) drive_ab(rev(ab_now), 20);
    check("stab_pos", 32'(paddle_pos), 200);
    check("stab_no_strobe", pv_count - pv_snap, 0);
    check("stab_dir", 32'(dir), 0);
    check("stab_err_sticky", 32'(err), 1);
    do_frame("stab", 180);

    // Reset with AB=11 held: first real sample must not count as a transition.
    do_reset(2'b11);
    cycles(20);
    check("prime_err", 32'(err), 0);
    check("prime_dir", 32'(dir), 0);
    do_frame("prime", 200);
    drive_ab(fwd(ab_now), 20);
    check("prime_step_dir", 32'(dir), 1);
    do_frame("prime_step", 202);

    // Tick in the same cycle as an accumulator update latches the old value.
    drive_ab(fwd(ab_now), LAT + 1);
    do_frame("coinc_old", 202);
    cycles(5);
    do_frame("coinc_new", 204);

    // Reset while a detected move is still pending: move is discarded.
    drive_ab(fwd(ab_now), 2);
    do_reset(ab_now);
    cycles(10);
    do_frame("rst_mid", 200);

`ifdef QUAD_GLITCH_FILTER_EN
    // Glitch filter: short A pulse ignored, long A hold gives one increment.
    do_reset(2'b00);
    drive_ab(2'b01, 20);
    do_frame("filt_base", 202);
    drive_ab(2'b11, 3);
    drive_ab(2'b01, 20);
    do_frame("filt_pulse", 202);
    drive_ab(2'b11, 10);
    cycles(10);
    check("filt_dir", 32'(dir), 1);
    check("filt_err", 32'(err), 0);
    do_frame("filt_hold", 204);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
